i2c_tx_feeder: RTL
==================

# i2c_tx_feeder

Transmit-byte feeder that sits directly upstream of `i2c_master`. It buffers bytes written by the host in a FIFO and presents them on the master's `I_I2CDR` input. It detects each rising edge of the master's transfer-complete flag (I2CSR MCF bit), pops the next byte and issues the one-cycle `I_TXRX_DONE` strobe the master expects. It replaces hand-driven data/done stimulus with a synthesizable, flow-controlled source.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries. Must be a power of two and at least 2.
- `AW`, 4: pointer width, equal to log2(`DEPTH`).

Ports:
- `I_CLK`  in  1  single clock for all logic.
- `I_RSTN`  in  1  reset, synchronous, active-low.
- `I_WR_EN`  in  1  host write strobe, one byte per cycle.
- `I_WR_DATA`  in  8  host byte.
- `I_FLUSH`  in  1  empties the FIFO.
- `I_CLR_ERR`  in  1  clears the sticky error flags.
- `I_MCF`  in  1  MCF bit of the master's I2CSR.
- `O_I2CDR`  out  8  byte to the master's `I_I2CDR`.
- `O_TXRX_DONE`  out  1  one-cycle strobe to the master's `I_TXRX_DONE`.
- `O_FULL`, `O_EMPTY`  out  1  FIFO status.
- `O_LEVEL`  out  AW+1  occupancy, range 0..`DEPTH`.
- `O_OVERRUN`, `O_UNDERRUN`  out  1  sticky error flags.

## Operation
- Storage: circular buffer with `wr_ptr` and `rd_ptr` (AW bits, wrap modulo `DEPTH`) and a `level` counter (AW+1 bits).
  - `O_FULL` = (level == DEPTH).
  - `O_EMPTY` = (level == 0).
- Edge detect: `mcf_d` holds the previous `I_MCF`. A pop request is `I_MCF & ~mcf_d`, evaluated each clock.
- Pop request while not empty:
  - `O_I2CDR` <= mem[rd_ptr];
  - `rd_ptr` increments;
  - `O_TXRX_DONE` <= 1 for exactly one cycle.
- Pop request while empty:
  - no strobe;
  - `O_I2CDR` holds its value;
  - `O_UNDERRUN` <= 1.
- Write while not full: mem[wr_ptr] <= `I_WR_DATA`, and `wr_ptr` increments.
- Write while full with no pop in the same cycle: the byte is dropped and `O_OVERRUN` <= 1.
- Write while full with a pop in the same cycle: the write is accepted and level stays at `DEPTH`.
- Write and pop in the same cycle while empty: no bypass. The pop underruns and the write is stored (level becomes 1).
- Write and pop in the same cycle otherwise: both execute and level is unchanged.
- `I_FLUSH` has priority over write and pop in the same cycle. It zeroes both pointers and level, suppresses the strobe, and leaves the sticky flags and `O_I2CDR` unchanged.
- `I_CLR_ERR` clears both sticky flags. If an error event occurs in the same cycle, the set wins.
- There is no FSM beyond the edge register. The pop path is a two-state idle/strobe sequence implied by the `O_TXRX_DONE` register.

## Timing
- Reset values while `I_RSTN`=0 at a clock edge:
  - `O_I2CDR`=8'h00, `O_TXRX_DONE`=0;
  - `O_EMPTY`=1, `O_FULL`=0, `O_LEVEL`=0;
  - `O_OVERRUN`=0, `O_UNDERRUN`=0;
  - pointers=0;
  - `mcf_d`=1, so an MCF that is already high at reset release produces no pop.
- Reset mid-operation: the FIFO contents are discarded and any pending strobe is cancelled on the next edge.
- Latency from MCF rise:
  - the first clock edge that samples `I_MCF`=1 with `mcf_d`=0 loads `O_I2CDR` and raises `O_TXRX_DONE`;
  - the strobe falls on the following edge.
- An MCF that stays high produces a single pop. A new pop needs MCF to go low for at least one sampled cycle.
- Write to status:
  - `O_LEVEL`, `O_EMPTY` and `O_FULL` update on the edge after `I_WR_EN`;
  - a byte written at edge k is poppable from edge k+1.
- Throughput: one write per cycle. At most one pop per two cycles, limited by the edge detect.

## Configuration
- `I2C_TXF_WATERMARK_EN` defined:
  - adds input `I_WMARK` (AW+1 bits) and output `O_WMARK_IRQ`;
  - `O_WMARK_IRQ` is registered, = (level <= `I_WMARK`) & ~`O_EMPTY`, and resets to 0.
- Not defined: neither port exists and no watermark logic is built.

## Structure
- The shared register bit-definition package holds:
  - the I2CSR bit index constant for MCF, used by the integration wrapper to slice I2CSR;
  - a new constant `I2C_TXF_DEPTH_DEF` = 16.
- One sub-module, `i2c_txf_ram`: `DEPTH`×8 storage with a synchronous write port and an asynchronous read port. It has no reset and is inferred as distributed RAM.
- The top level holds the pointers, level counter, edge detect, flags and output registers.

## Test plan
- Reset, then write AA, 12, 34 on consecutive cycles -> `O_LEVEL`=3, `O_EMPTY`=0. Three MCF pulses (high 4 cycles, low 20) -> `O_I2CDR` = AA, 12, 34 in order, with exactly 3 single-cycle `O_TXRX_DONE` strobes, each one clock after the MCF rise is sampled.
- MCF pulse with the FIFO empty -> no strobe, `O_I2CDR` unchanged, `O_UNDERRUN`=1. `I_CLR_ERR` -> 0.
- Write 17 bytes with `DEPTH`=16 -> `O_FULL`=1, `O_LEVEL`=16, `O_OVERRUN`=1, and the 17th byte is not read back. Write together with a pop at full -> level stays 16.
- `I_MCF` held high across reset release -> no strobe until MCF falls and rises again.
- Fill with 5 bytes, then `I_FLUSH` in the same cycle as an MCF rise and a write -> level 0, no strobe, `O_I2CDR` unchanged.
- With `I2C_TXF_WATERMARK_EN` and `I_WMARK`=2: level 4 -> 2 -> `O_WMARK_IRQ` rises the edge after level reaches 2, and falls when level reaches 0.

Source files
------------

// File: rtl/i2c_tx_feeder_pkg.sv
// Shared I2C register bit definitions and transmit-feeder defaults.
package i2c_tx_feeder_pkg;

    // I2CSR bit index of MCF (transfer complete), sliced by the integration wrapper.
    localparam int I2CSR_MCF_BIT     = 7;
    localparam int I2C_TXF_DEPTH_DEF = 16;

endpackage

// File: rtl/i2c_tx_feeder_ram.sv
// i2c_txf_ram: DEPTH x 8 storage, synchronous write, asynchronous read, no reset.
module i2c_txf_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/i2c_tx_feeder.sv
// Transmit-byte feeder for i2c_master: host FIFO popped on each MCF rising edge.
// Optional watermark interrupt built when I2C_TXF_WATERMARK_EN is defined.
module i2c_tx_feeder
    import i2c_tx_feeder_pkg::*;
#(
    parameter int DEPTH = I2C_TXF_DEPTH_DEF,
    parameter int AW    = 4
) (
    input  logic          I_CLK,
    input  logic          I_RSTN,
    input  logic          I_WR_EN,
    input  logic [7:0]    I_WR_DATA,
    input  logic          I_FLUSH,
    input  logic          I_CLR_ERR,
    input  logic          I_MCF,
`ifdef I2C_TXF_WATERMARK_EN
    input  logic [AW:0]   I_WMARK,
    output logic          O_WMARK_IRQ,
`endif
    output logic [7:0]    O_I2CDR,
    output logic          O_TXRX_DONE,
    output logic          O_FULL,
    output logic          O_EMPTY,
    output logic [AW:0]   O_LEVEL,
    output logic          O_OVERRUN,
    output logic          O_UNDERRUN
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          mcf_prev_q, mcf_prev_d;
    logic [7:0]    dr_q, dr_d;
    logic          done_q, done_d;
    logic          overrun_q, overrun_d;
    logic          underrun_q, underrun_d;

    logic          full, empty, pop_req, do_pop, do_wr;
    logic [7:0]    rd_data;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign pop_req = I_MCF & ~mcf_prev_q;
    assign do_pop  = pop_req & ~empty & ~I_FLUSH;
    // A pop in the same cycle frees the slot, so a write at full is still accepted.
    assign do_wr   = I_WR_EN & ~I_FLUSH & (~full | do_pop);

    i2c_txf_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (I_CLK),
        .we    (do_wr),
        .waddr (wr_ptr_q),
        .wdata (I_WR_DATA),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        dr_d       = dr_q;
        done_d     = 1'b0;
        mcf_prev_d = I_MCF;
        overrun_d  = I_CLR_ERR ? 1'b0 : overrun_q;
        underrun_d = I_CLR_ERR ? 1'b0 : underrun_q;

        if (I_FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_pop) begin
                dr_d     = rd_data;
                done_d   = 1'b1;
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            case ({do_wr, do_pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
            // Error events override a same-cycle clear.
            if (pop_req && empty) begin
                underrun_d = 1'b1;
            end
            if (I_WR_EN && full && !do_pop) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RSTN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            mcf_prev_q <= 1'b1;
            dr_q       <= 8'h00;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            mcf_prev_q <= mcf_prev_d;
            dr_q       <= dr_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef I2C_TXF_WATERMARK_EN
    logic wmark_q, wmark_d;

    assign wmark_d = (level_q <= I_WMARK) & ~empty;

    always_ff @(posedge I_CLK) begin
        if (!I_RSTN) begin
            wmark_q <= 1'b0;
        end else begin
            wmark_q <= wmark_d;
        end
    end

    assign O_WMARK_IRQ = wmark_q;
`endif

    assign O_I2CDR     = dr_q;
    assign O_TXRX_DONE = done_q;
    assign O_FULL      = full;
    assign O_EMPTY     = empty;
    assign O_LEVEL     = level_q;
    assign O_OVERRUN   = overrun_q;
    assign O_UNDERRUN  = underrun_q;

endmodule
